// File: rtl/serial_lane_pkg.sv
// Shared types and sizing helpers for the serial lane driver.
// State encodings, default geometry and counter-width functions.
package serial_lane_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_GAP_CYCLES = 1;

  // Bits needed to index 0..n-1.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Bits needed to hold an occupancy of 0..n.
  function automatic int occ_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_lane_driver_fifo.sv
// Small synchronous byte buffer feeding the lane serialiser.
// Power-of-two depth; pointers wrap naturally.
module lane_byte_fifo
  import serial_lane_pkg::*;
#(
  parameter int W     = DEF_DATA_W,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [W-1:0]              wdata,
  output logic [W-1:0]              rdata,
  output logic                      full,
  output logic                      empty,
  output logic [occ_w(DEPTH)-1:0]   count
);

  localparam int AW = cnt_w(DEPTH);
  localparam int CW = occ_w(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/serial_lane_driver.sv
// Byte-to-three-lane serialiser (data, frame strobe, parity), MSB first.
// Define SERIAL_LANE_PARITY_EN to add the even-parity PAR cycle on out_c.
module serial_lane_driver
  import serial_lane_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_a,
  output logic              out_b,
  output logic              out_c,
  output logic              busy
);

  localparam int BW = cnt_w(DATA_W);
  localparam int CW = occ_w(FIFO_DEPTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic [3:0]    GAP_LAST = 4'(GAP_CYCLES - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [3:0]        gap_cnt_q, gap_cnt_d;
  logic              out_a_q, out_a_d;
  logic              out_b_q, out_b_d;
  logic              out_c_q, out_c_d;
  logic              busy_q, busy_d;
`ifdef SERIAL_LANE_PARITY_EN
  logic              par_q, par_d;
`endif

  logic              push;
  logic              pop;
  logic              done;
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;

  assign in_ready = ~fifo_full;
  assign push     = in_valid & in_ready;

  lane_byte_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    out_a_d   = 1'b0;
    out_b_d   = 1'b0;
    out_c_d   = 1'b0;
    pop       = 1'b0;
    done      = 1'b0;
`ifdef SERIAL_LANE_PARITY_EN
    par_d     = par_q;
`endif
    unique case (state_q)
      ST_IDLE: done = 1'b1;
      ST_SHIFT: begin
        out_a_d   = shift_q[DATA_W-1];
        out_b_d   = 1'b1;
        shift_d   = shift_q << 1;
        bit_cnt_d = bit_cnt_q + BW'(1);
        if (bit_cnt_q == BIT_LAST) begin
`ifdef SERIAL_LANE_PARITY_EN
          state_d = ST_PAR;
`else
          if (GAP_CYCLES > 0) begin
            state_d   = ST_GAP;
            gap_cnt_d = '0;
          end else begin
            done = 1'b1;
          end
`endif
        end
      end
`ifdef SERIAL_LANE_PARITY_EN
      ST_PAR: begin
        out_c_d = par_q;
        if (GAP_CYCLES > 0) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
        end else begin
          done = 1'b1;
        end
      end
`endif
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q + 4'd1;
        if (gap_cnt_q == GAP_LAST) done = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // Last cycle of a frame loads the next byte directly when one waits.
    if (done) begin
      if (!fifo_empty) begin
        pop       = 1'b1;
        shift_d   = fifo_rdata;
        bit_cnt_d = '0;
        state_d   = ST_SHIFT;
`ifdef SERIAL_LANE_PARITY_EN
        par_d     = ^fifo_rdata;
`endif
      end else begin
        state_d = ST_IDLE;
      end
    end
    busy_d = (state_q != ST_IDLE) || (fifo_count != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      out_a_q   <= 1'b0;
      out_b_q   <= 1'b0;
      out_c_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef SERIAL_LANE_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      out_a_q   <= out_a_d;
      out_b_q   <= out_b_d;
      out_c_q   <= out_c_d;
      busy_q    <= busy_d;
`ifdef SERIAL_LANE_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign out_a = out_a_q;
  assign out_b = out_b_q;
  assign out_c = out_c_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_serial_lane_driver.sv
// Bench for serial_lane_driver: two instances (GAP 1 and GAP 0) vs a frame-queue model.
// Test 1: 0xA5 MSB-first; with parity on, out_c=0 in the PAR cycle (0xA5 has 4 ones).
`timescale 1ns/1ps
module tb_serial_lane_driver;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int NI    = 2;
  localparam int LQ    = 16;
  localparam int RXN   = 1024;
`ifdef SERIAL_LANE_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [NI-1:0] rdy, oa, ob, oc, bsy;

  int n_tests = 0;
  int n_fail  = 0;

  serial_lane_driver #(
    .DATA_W(DW), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(1)
  ) u_dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[0]), .out_a(oa[0]), .out_b(ob[0]), .out_c(oc[0]),
    .busy(bsy[0])
  );

  serial_lane_driver #(
    .DATA_W(DW), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(0)
  ) u_dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[1]), .out_a(oa[1]), .out_b(ob[1]), .out_c(oc[1]),
    .busy(bsy[1])
  );

  always #5 clk = ~clk;

  function automatic int gap_of(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  task automatic chk(input string nm, input int i,
                     input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t",
               nm, i, got, exp, $time);
    end
  endtask

  // Model: byte queue plus a queue of lane triples {a,b,c}, one per frame cycle.
  logic [DW-1:0] fq [NI][DEPTH];
  int            fhead [NI];
  int            fcnt  [NI];
  logic [2:0]    lq [NI][LQ];
  int            lhead [NI];
  int            lcnt  [NI];
  logic [2:0]    e_lane [NI];
  logic          e_busy [NI];
  logic          e_rdy  [NI];
  bit            chk_en = 1'b0;

  task automatic lq_push(input int i, input logic [2:0] v);
    lq[i][(lhead[i] + lcnt[i]) % LQ] = v;
    lcnt[i]++;
  endtask

  task automatic add_frame(input int i, input logic [DW-1:0] b);
    for (int k = DW - 1; k >= 0; k--) lq_push(i, {b[k], 2'b10});
    if (PAR != 0) lq_push(i, {2'b00, ^b});
    for (int g = 0; g < gap_of(i); g++) lq_push(i, 3'b000);
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        fcnt[i] = 0; fhead[i] = 0; lcnt[i] = 0; lhead[i] = 0;
        e_lane[i] = 3'b000; e_busy[i] = 1'b0; e_rdy[i] = 1'b1;
      end else begin : step
        logic          ok;
        logic [DW-1:0] b;
        ok = (fcnt[i] < DEPTH);
        e_busy[i] = (lcnt[i] > 0) || (fcnt[i] > 0);
        if (lcnt[i] > 0) begin
          e_lane[i] = lq[i][lhead[i]];
          lhead[i] = (lhead[i] + 1) % LQ;
          lcnt[i]--;
        end else begin
          e_lane[i] = 3'b000;
        end
        if (lcnt[i] == 0 && fcnt[i] > 0) begin
          b = fq[i][fhead[i]];
          fhead[i] = (fhead[i] + 1) % DEPTH;
          fcnt[i]--;
          add_frame(i, b);
        end
        if (in_valid && ok) begin
          fq[i][(fhead[i] + fcnt[i]) % DEPTH] = in_data;
          fcnt[i]++;
        end
        e_rdy[i] = (fcnt[i] < DEPTH);
      end
    end
    if (rst) chk_en = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        chk("lanes", i, 32'({oa[i], ob[i], oc[i]}), 32'(e_lane[i]));
        chk("busy", i, 32'(bsy[i]), 32'(e_busy[i]));
        chk("in_ready", i, 32'(rdy[i]), 32'(e_rdy[i]));
      end
    end
  end

  // Receiver: rebuild bytes from strobed bits for the literal checks.
  logic [DW-1:0] sh   [NI];
  int            bitn [NI];
  logic [DW-1:0] rx   [NI][RXN];
  int            rxn  [NI];
  int            run1 = 0;
  int            maxrun1 = 0;

  always @(posedge clk) begin
    if (rst) for (int i = 0; i < NI; i++) bitn[i] = 0;
  end

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (ob[i] === 1'b1) begin
        sh[i] = {sh[i][DW-2:0], oa[i]};
        bitn[i]++;
        if (bitn[i] == DW) begin
          if (rxn[i] < RXN) rx[i][rxn[i]] = sh[i];
          rxn[i]++;
          bitn[i] = 0;
        end
      end
    end
    if (ob[1] === 1'b1) run1++;
    else run1 = 0;
    if (run1 > maxrun1) maxrun1 = run1;
  end

  task automatic push1(input logic [DW-1:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    int base;
    int cnt;
    int dens;
    bit saw_full;
    bit sent;
    bit acc;

    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_lanes", 0, 32'({oa[0], ob[0], oc[0]}), 32'd0);
    chk("rst_ready", 0, 32'(rdy[0]), 32'd1);
    chk("rst_busy", 0, 32'(bsy[0]), 32'd0);
    rst = 1'b0;

    // 0xA5: latency and bit order
    base = rxn[0];
    push1(8'hA5);
    @(negedge clk);
    chk("t1_lat", 0, 32'(ob[0]), 32'd0);
    @(negedge clk);
    chk("t1_first", 0, 32'({oa[0], ob[0]}), 32'b11);
    repeat (8) @(negedge clk);
    chk("t1_par", 0, 32'({ob[0], oc[0]}), 32'b00);
    repeat (4) @(negedge clk);
    chk("t1_count", 0, 32'(rxn[0] - base), 32'd1);
    chk("t1_byte", 0, 32'(rx[0][base]), 32'hA5);

    // 0x07: parity cycle, gap, busy fall
    repeat (20) @(negedge clk);
    base = rxn[0];
    push1(8'h07);
    repeat (10) @(negedge clk);
    chk("t2_par", 0, 32'({ob[0], oc[0]}), 32'(PAR != 0));
    repeat (PAR) @(negedge clk);
    chk("t2_gap_lanes", 0, 32'({oa[0], ob[0], oc[0]}), 32'd0);
    chk("t2_busy_gap", 0, 32'(bsy[0]), 32'd1);
    @(negedge clk);
    chk("t2_busy_fall", 0, 32'(bsy[0]), 32'd0);
    repeat (2) @(negedge clk);
    chk("t2_byte", 0, 32'(rx[0][base]), 32'h07);

    // Six bytes with valid held: backpressure and ordering
    repeat (20) @(negedge clk);
    base = rxn[0];
    saw_full = 1'b0;
    for (int b = 1; b <= 6; b++) begin
      in_data  = 8'(b);
      in_valid = 1'b1;
      sent     = 1'b0;
      for (int t = 0; t < 40 && !sent; t++) begin
        acc = rdy[0];
        if (!acc) saw_full = 1'b1;
        @(negedge clk);
        sent = acc;
      end
      chk("t3_accept", 0, 32'(sent), 32'd1);
    end
    in_valid = 1'b0;
    chk("t3_ready_low", 0, 32'(saw_full), 32'd1);
    repeat (80) @(negedge clk);
    chk("t3_count", 0, 32'(rxn[0] - base), 32'd6);
    for (int k = 0; k < 6; k++)
      chk("t3_order", 0, 32'(rx[0][base + k]), 32'(k + 1));

    // GAP 0 back-to-back 0xFF, 0x00
    repeat (40) @(negedge clk);
    base = rxn[1];
    maxrun1 = 0;
    push1(8'hFF);
    push1(8'h00);
    repeat (24) @(negedge clk);
    chk("t4_run", 1, 32'(maxrun1), (PAR != 0) ? 32'd8 : 32'd16);
    chk("t4_byte0", 1, 32'(rx[1][base]), 32'hFF);
    chk("t4_byte1", 1, 32'(rx[1][base + 1]), 32'h00);

    // Reset on the 4th bit of 0xC3 with two bytes queued
    repeat (30) @(negedge clk);
    push1(8'hC3);
    push1(8'h11);
    push1(8'h22);
    chk("t5_bit1", 0, 32'({oa[0], ob[0]}), 32'b11);
    @(negedge clk);
    chk("t5_bit2", 0, 32'({oa[0], ob[0]}), 32'b11);
    @(negedge clk);
    chk("t5_bit3", 0, 32'({oa[0], ob[0]}), 32'b01);
    @(negedge clk);
    chk("t5_bit4", 0, 32'({oa[0], ob[0]}), 32'b01);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_lanes", 0, 32'({oa[0], ob[0], oc[0]}), 32'd0);
    chk("t5_ready", 0, 32'(rdy[0]), 32'd1);
    chk("t5_busy", 0, 32'(bsy[0]), 32'd0);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (ob[0] === 1'b1) cnt++;
    end
    chk("t5_silent", 0, 32'(cnt), 32'd0);

    // Push and pop on the same edge at count 3
    repeat (10) @(negedge clk);
    push1(8'h01);
    push1(8'h02);
    push1(8'h03);
    push1(8'h04);
    repeat (6 + PAR) @(negedge clk);
    chk("t6_ready_pre", 0, 32'(rdy[0]), 32'd1);
    push1(8'h05);
    chk("t6_ready_same", 0, 32'(rdy[0]), 32'd1);

    // Randomised traffic with varying density and rare resets
    repeat (60) @(negedge clk);
    dens = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) dens = $urandom_range(5, 100);
      in_valid = ($urandom_range(0, 99) < dens);
      in_data  = 8'($urandom);
      rst      = ($urandom_range(0, 399) == 0);
      @(negedge clk);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (60) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
